// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: serves a latched button request on the next
// red-entry edge of the vehicle light with WALK, then a blinking FLASH phase.
module ped_crossing_ctrl #(
   parameter int unsigned WALK_TIME  = 3,
   parameter int unsigned FLASH_TIME = 4,
   parameter int unsigned BLINK_HALF = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] light_color,
   input  logic       ped_button,
   output logic       walk,
   output logic       dont_walk,
   output logic       request_pending,
   output logic [7:0] countdown,
   output logic       fault
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WALK, ST_FLASH} state_e;

   localparam logic [7:0] WALK_LD  = 8'(WALK_TIME);
   localparam logic [7:0] FLASH_LD = 8'(FLASH_TIME);
   localparam logic [3:0] BLINK_LD = 4'(BLINK_HALF);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic       prev_red_q;
   logic       latch_q, latch_d;
   logic       fault_q, fault_d;
   logic       walk_q, walk_d;
   logic       dw_q, dw_d;
   logic       pend_q, pend_d;

   logic red, illegal, red_entry;

   function automatic logic [7:0] sat_dec(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

   assign red       = (light_color == 2'b10);
   assign illegal   = (light_color == 2'b11);
   assign red_entry = red && !prev_red_q;

   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      fault_d = fault_q;
      cnt_d   = 8'd0;
      bcnt_d  = 4'd1;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      if (illegal) begin
         fault_d = 1'b1;
         state_d = ST_IDLE;
         latch_d = 1'b0;
      end else if (fault_q) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (ped_button) state_d = ST_WAIT;
            ST_WAIT: begin
               if (red_entry) begin
                  state_d = ST_WALK;
                  walk_d  = 1'b1;
                  dw_d    = 1'b0;
                  cnt_d   = WALK_LD;
               end
            end
            ST_WALK: begin
               // Leaving WALK/FLASH early or at the end: a pending request goes straight back to WAIT
               if (!red) begin
                  state_d = (latch_q || ped_button) ? ST_WAIT : ST_IDLE;
                  latch_d = 1'b0;
               end else if (cnt_q <= 8'd1) begin
                  state_d = ST_FLASH;
                  cnt_d   = FLASH_LD;
                  latch_d = latch_q || ped_button;
               end else begin
                  walk_d  = 1'b1;
                  dw_d    = 1'b0;
                  cnt_d   = sat_dec(cnt_q);
                  latch_d = latch_q || ped_button;
               end
            end
            ST_FLASH: begin
               if (!red || cnt_q <= 8'd1) begin
                  state_d = (latch_q || ped_button) ? ST_WAIT : ST_IDLE;
                  latch_d = 1'b0;
               end else begin
                  cnt_d   = sat_dec(cnt_q);
                  latch_d = latch_q || ped_button;
                  if (bcnt_q >= BLINK_LD) begin
                     dw_d   = ~dw_q;
                     bcnt_d = 4'd1;
                  end else begin
                     dw_d   = dw_q;
                     bcnt_d = bcnt_q + 4'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      pend_d = (state_d == ST_WAIT) || latch_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         bcnt_q     <= 4'd1;
         prev_red_q <= 1'b1;
         latch_q    <= 1'b0;
         fault_q    <= 1'b0;
         walk_q     <= 1'b0;
         dw_q       <= 1'b1;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bcnt_q     <= bcnt_d;
         prev_red_q <= red;
         latch_q    <= latch_d;
         fault_q    <= fault_d;
         walk_q     <= walk_d;
         dw_q       <= dw_d;
         pend_q     <= pend_d;
      end
   end

   assign walk            = walk_q;
   assign dont_walk       = dw_q;
   assign request_pending = pend_q;
   assign countdown       = cnt_q;
   assign fault           = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with hand-computed expected lamp,
// countdown, request and fault values.
module tb_ped_crossing_ctrl;

   localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, BAD = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] light_color;
   logic       ped_button;
   logic       walk, dont_walk, request_pending, fault;
   logic [7:0] countdown;

   int n_checks = 0;
   int n_fail   = 0;

   ped_crossing_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .light_color     (light_color),
      .ped_button      (ped_button),
      .walk            (walk),
      .dont_walk       (dont_walk),
      .request_pending (request_pending),
      .countdown       (countdown),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // walk, dont_walk, request_pending, countdown, fault
   task automatic expect_out(input string tag, input int w, input int dw,
                             input int rp, input int cd, input int f);
      chk({tag, ".walk"}, int'(walk), w);
      chk({tag, ".dont_walk"}, int'(dont_walk), dw);
      chk({tag, ".pending"}, int'(request_pending), rp);
      chk({tag, ".countdown"}, int'(countdown), cd);
      chk({tag, ".fault"}, int'(fault), f);
   endtask

   int flash_dw[4] = '{1, 0, 1, 0};

   initial begin
      reset = 1'b1;
      light_color = GREEN;
      ped_button = 1'b0;
      #2;
      expect_out("reset", 0, 1, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      // Full cycle: button on green, red after 3 cycles, WALK then FLASH then IDLE
      step();
      expect_out("idle0", 0, 1, 0, 0, 0);
      ped_button = 1'b1;
      step();
      expect_out("wait_enter", 0, 1, 1, 0, 0);
      ped_button = 1'b0;
      step();
      step();
      expect_out("wait_green", 0, 1, 1, 0, 0);
      light_color = RED;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out($sformatf("walk%0d", i), 1, 0, 0, 3 - i, 0);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out($sformatf("flash%0d", i), 0, flash_dw[i], 0, 4 - i, 0);
      end
      step();
      expect_out("after_flash", 0, 1, 0, 0, 0);

      // Button while red already in progress: no WALK until a new red entry
      ped_button = 1'b1;
      step();
      ped_button = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out($sformatf("red_held%0d", i), 0, 1, 1, 0, 0);
      end
      light_color = GREEN;
      step();
      expect_out("wait_green2", 0, 1, 1, 0, 0);
      light_color = RED;
      step();
      expect_out("walk_new_entry", 1, 0, 0, 3, 0);
      step();
      expect_out("walk_cyc2", 1, 0, 0, 2, 0);

      // Yellow during WALK aborts to IDLE
      light_color = YELLOW;
      step();
      expect_out("abort", 0, 1, 0, 0, 0);
      step();
      expect_out("abort_stay", 0, 1, 0, 0, 0);

      // Button during FLASH returns to WAIT instead of IDLE
      light_color = GREEN;
      ped_button = 1'b1;
      step();
      ped_button = 1'b0;
      light_color = RED;
      step();
      expect_out("walk_b", 1, 0, 0, 3, 0);
      step();
      step();
      step();
      expect_out("flash_b0", 0, 1, 0, 4, 0);
      ped_button = 1'b1;
      step();
      expect_out("flash_b1", 0, 0, 1, 3, 0);
      ped_button = 1'b0;
      step();
      step();
      expect_out("flash_b3", 0, 0, 1, 1, 0);
      step();
      expect_out("rewait", 0, 1, 1, 0, 0);

      // Illegal code in WAIT: sticky fault, buttons ignored
      light_color = BAD;
      step();
      expect_out("fault_set", 0, 1, 0, 0, 1);
      light_color = GREEN;
      ped_button = 1'b1;
      step();
      expect_out("fault_btn", 0, 1, 0, 0, 1);
      ped_button = 1'b0;
      light_color = RED;
      step();
      step();
      expect_out("fault_red", 0, 1, 0, 0, 1);
      #2;
      reset = 1'b1;
      #1;
      expect_out("fault_reset", 0, 1, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-WALK, red held through release
      light_color = GREEN;
      ped_button = 1'b1;
      step();
      ped_button = 1'b0;
      light_color = RED;
      step();
      step();
      expect_out("walk_c", 1, 0, 0, 2, 0);
      #3;
      reset = 1'b1;
      #1;
      expect_out("reset_mid_walk", 0, 1, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      ped_button = 1'b1;
      step();
      expect_out("post_reset_wait", 0, 1, 1, 0, 0);
      ped_button = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out($sformatf("post_reset_red%0d", i), 0, 1, 1, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
